bus_protocol_initiator: RTL and testbench
=========================================

// Module: bus_protocol_initiator
// PURPOSE
// - Protocol-side master for bus_protocol_if: drives wen/ren/addr/wdata/strobe, consumes rdata/error/request_stall.
// - Buffers queued commands in a FIFO and issues them one at a time, honouring stalls.
// - Returns one response per command; an optional stall timeout aborts hung transfers.
// - Used as the bus-side driver for peripheral_vital slaves (e.g. AHBUart) in integration and standalone benches.
// PARAMETERS
// ADDR_WIDTH      32  address width; matches bus_protocol_if
// DATA_WIDTH      32  data width; multiple of 8; strobe is DATA_WIDTH/8 bits
// CMD_DEPTH       4   command FIFO entries; power of 2, >=2
// TIMEOUT_CYCLES  16  max consecutive stalled cycles before abort; 0 disables timeout
// PORTS
// clk          in   1             system clock; all logic on rising edge
// reset        in   1             synchronous, active-high reset
// cmd_valid    in   1             command offered
// cmd_ready    out  1             FIFO can accept (= !full)
// cmd_write    in   1             1 = write, 0 = read
// cmd_addr     in   ADDR_WIDTH    offset address
// cmd_wdata    in   DATA_WIDTH    write data (ignored for reads)
// cmd_strobe   in   DATA_WIDTH/8  byte enables (ignored for reads)
// rsp_valid    out  1             response available
// rsp_ready    in   1             response consumed
// rsp_rdata    out  DATA_WIDTH    read data; 0 for writes and timeouts
// rsp_error    out  1             slave error or timeout
// rsp_timeout  out  1             transfer aborted by timeout
// busy         out  1             FIFO non-empty or FSM not IDLE
// wen, ren     out  1 each        bus request (never both high)
// addr         out  ADDR_WIDTH    bus address
// wdata        out  DATA_WIDTH    bus write data
// strobe       out  DATA_WIDTH/8  bus byte enables; 0 on reads
// rdata        in   DATA_WIDTH    slave read data
// error        in   1             slave error, valid on completion cycle
// request_stall in  1             slave wait state
// BEHAVIOUR
// - Reset: all outputs 0 except cmd_ready=1. FIFO emptied, FSM to IDLE, stall counter 0.
// - Reset mid-transfer drops wen/ren at that edge. No response is produced for the dropped transfer.
// - Command push on cmd_valid&&cmd_ready. FIFO order is strict. No fall-through: a command pushed in IDLE pops on the next edge at the earliest.
// - FSM IDLE: if FIFO non-empty, pop into issue registers, go REQ. Bus outputs are registered; in IDLE wen=ren=0 and addr/wdata/strobe=0.
// - FSM REQ: wen=cmd_write, ren=!cmd_write; addr/wdata/strobe held stable for the whole request.
//   - Completion: any edge in REQ with request_stall=0. Capture rdata (reads only, else 0) and error, go RESP, drop wen/ren.
//   - Stall: request_stall=1 increments stall_cnt.
//   - Timeout: TIMEOUT_CYCLES>0 and stall_cnt==TIMEOUT_CYCLES-1 with request_stall still 1. Go RESP with rsp_error=1, rsp_timeout=1, rsp_rdata=0.
//   - A timed-out request therefore sees exactly TIMEOUT_CYCLES stalled cycles.
// - FSM RESP: rsp_valid=1 with rsp_* stable until the rsp_ready edge. Then clear rsp_valid and go IDLE. stall_cnt is cleared on entry to REQ.
// - Latency:
//   - Command pushed at edge N into an empty FIFO with FSM in IDLE: wen/ren high after edge N+1.
//   - Zero-stall completion at edge N+2; rsp_valid high after N+2.
//   - Each stall cycle adds 1. Back-to-back commands have 2 idle bus cycles between requests (RESP, IDLE).
// - FIFO: count width clog2(CMD_DEPTH)+1; pointers wrap modulo CMD_DEPTH.
//   - Simultaneous push and pop on a non-empty, non-full FIFO keeps the count unchanged.
//   - No push when full, even if a pop occurs the same cycle (cmd_ready from registered count).
// - busy = (count!=0) || state!=IDLE.
// TESTING
// - Reset with cmd_valid=1 -> cmd_ready=1, wen=ren=0, rsp_valid=0, no push. After release, push W addr=24 wdata=0x0F strobe=0xF -> wen high at N+1 with addr=24/wdata=0x0F; stall=0 -> rsp_valid, rsp_error=0, rsp_rdata=0.
// - Read addr=0x8, request_stall=1 for 3 cycles, rdata=0xDEADBEEF on release -> ren held 4 cycles with addr stable, rsp_rdata=0xDEADBEEF.
// - Push 5 commands with CMD_DEPTH=4 and rsp_ready=0 -> cmd_ready low after the 4th accepted; responses returned in push order as rsp_ready pulses.
// - TIMEOUT_CYCLES=16, request_stall stuck 1 -> ren drops after exactly 16 stalled cycles; rsp_error=1, rsp_timeout=1, rsp_rdata=0; next command proceeds normally.
// - Slave error=1 on completion of a write -> rsp_error=1, rsp_timeout=0. Assert reset during a stalled request -> wen=0 at that edge, FIFO empty, busy=0, no rsp_valid.

Source files
------------

// File: rtl/bus_protocol_if.sv
// ---------------------------------------------------------------------------
// bus_protocol_if
// Bus between a protocol initiator (master) and a peripheral slave.
//   wen/ren        master -> slave  request strobes (never both high)
//   addr           master -> slave  request address
//   wdata/strobe   master -> slave  write data and byte enables
//   rdata          slave  -> master read data, valid on the completion cycle
//   error          slave  -> master slave error, valid on the completion cycle
//   request_stall  slave  -> master wait state; request held while high
// ---------------------------------------------------------------------------
interface bus_protocol_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      wen;
    logic                      ren;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   strobe;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      error;
    logic                      request_stall;

    modport master (
        output wen, ren, addr, wdata, strobe,
        input  rdata, error, request_stall
    );

    modport slave (
        input  wen, ren, addr, wdata, strobe,
        output rdata, error, request_stall
    );
endinterface

// File: rtl/bus_protocol_initiator.sv
// ---------------------------------------------------------------------------
// bus_protocol_initiator
// Queues commands in a FIFO and issues them one at a time on bus_protocol_if,
// honouring slave stalls, and returns one response per command. A stall
// timeout (TIMEOUT_CYCLES > 0) aborts a request that stays stalled.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cmd_*               command push interface (valid/ready)
//   rsp_*               response interface (valid/ready), stable until taken
//   busy                FIFO non-empty or transfer in progress
//   bus                 bus_protocol_if master modport (all outputs registered)
// ---------------------------------------------------------------------------
module bus_protocol_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strobe,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic                    busy,
    bus_protocol_if.master          bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(CMD_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STL_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [STL_W-1:0] STALL_LAST =
        (TIMEOUT_CYCLES > 0) ? STL_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RESP = 2'd2} state_t;

    state_t                  state_r, state_next_s;
    logic                    fifo_write_r  [CMD_DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_addr_r   [CMD_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_wdata_r  [CMD_DEPTH];
    logic [STRB_W-1:0]       fifo_strobe_r [CMD_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]        count_r, count_next_s;
    logic                    push_s, pop_s, timeout_hit_s;
    logic [STL_W-1:0]        stall_cnt_r, stall_next_s;
    logic                    wen_r, wen_next_s, ren_r, ren_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_next_s;
    logic [DATA_WIDTH-1:0]   wdata_r, wdata_next_s;
    logic [STRB_W-1:0]       strobe_r, strobe_next_s;
    logic                    rsp_valid_r, rsp_valid_next_s;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r, rsp_rdata_next_s;
    logic                    rsp_error_r, rsp_error_next_s;
    logic                    rsp_timeout_r, rsp_timeout_next_s;
    logic                    cmd_ready_r, busy_r;

    // cmd_ready comes from the registered count, so a full FIFO refuses a
    // push even on the cycle it pops.
    assign push_s = cmd_valid && cmd_ready_r;

    // Next-state and next-value logic for the FSM and its registered outputs.
    always_comb begin
        state_next_s       = state_r;
        pop_s              = 1'b0;
        stall_next_s       = stall_cnt_r;
        wen_next_s         = wen_r;
        ren_next_s         = ren_r;
        addr_next_s        = addr_r;
        wdata_next_s       = wdata_r;
        strobe_next_s      = strobe_r;
        rsp_valid_next_s   = rsp_valid_r;
        rsp_rdata_next_s   = rsp_rdata_r;
        rsp_error_next_s   = rsp_error_r;
        rsp_timeout_next_s = rsp_timeout_r;
        timeout_hit_s      = (TIMEOUT_CYCLES > 0) && (stall_cnt_r == STALL_LAST);
        case (state_r)
            ST_IDLE: begin
                if (count_r != '0) begin
                    pop_s         = 1'b1;
                    state_next_s  = ST_REQ;
                    stall_next_s  = '0;
                    wen_next_s    = fifo_write_r[rd_ptr_r];
                    ren_next_s    = !fifo_write_r[rd_ptr_r];
                    addr_next_s   = fifo_addr_r[rd_ptr_r];
                    wdata_next_s  = fifo_write_r[rd_ptr_r] ? fifo_wdata_r[rd_ptr_r] : '0;
                    strobe_next_s = fifo_write_r[rd_ptr_r] ? fifo_strobe_r[rd_ptr_r] : '0;
                end else begin
                    wen_next_s    = 1'b0;
                    ren_next_s    = 1'b0;
                    addr_next_s   = '0;
                    wdata_next_s  = '0;
                    strobe_next_s = '0;
                end
            end
            ST_REQ: begin
                if (!bus.request_stall) begin
                    // Completion: capture the slave response, release the bus.
                    state_next_s       = ST_RESP;
                    rsp_valid_next_s   = 1'b1;
                    rsp_rdata_next_s   = ren_r ? bus.rdata : '0;
                    rsp_error_next_s   = bus.error;
                    rsp_timeout_next_s = 1'b0;
                    wen_next_s         = 1'b0;
                    ren_next_s         = 1'b0;
                    addr_next_s        = '0;
                    wdata_next_s       = '0;
                    strobe_next_s      = '0;
                end else if (timeout_hit_s) begin
                    // This edge is the TIMEOUT_CYCLES-th stalled one: abort.
                    state_next_s       = ST_RESP;
                    rsp_valid_next_s   = 1'b1;
                    rsp_rdata_next_s   = '0;
                    rsp_error_next_s   = 1'b1;
                    rsp_timeout_next_s = 1'b1;
                    wen_next_s         = 1'b0;
                    ren_next_s         = 1'b0;
                    addr_next_s        = '0;
                    wdata_next_s       = '0;
                    strobe_next_s      = '0;
                end else begin
                    stall_next_s = stall_cnt_r + STL_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next_s       = ST_IDLE;
                    rsp_valid_next_s   = 1'b0;
                    rsp_rdata_next_s   = '0;
                    rsp_error_next_s   = 1'b0;
                    rsp_timeout_next_s = 1'b0;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s  = ST_IDLE;
                wen_next_s    = 1'b0;
                ren_next_s    = 1'b0;
                addr_next_s   = '0;
                wdata_next_s  = '0;
                strobe_next_s = '0;
            end
        endcase
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FSM state, FIFO pointers/count and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            stall_cnt_r   <= '0;
            wen_r         <= 1'b0;
            ren_r         <= 1'b0;
            addr_r        <= '0;
            wdata_r       <= '0;
            strobe_r      <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_error_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
            cmd_ready_r   <= 1'b1;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            wr_ptr_r      <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r      <= pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            count_r       <= count_next_s;
            stall_cnt_r   <= stall_next_s;
            wen_r         <= wen_next_s;
            ren_r         <= ren_next_s;
            addr_r        <= addr_next_s;
            wdata_r       <= wdata_next_s;
            strobe_r      <= strobe_next_s;
            rsp_valid_r   <= rsp_valid_next_s;
            rsp_rdata_r   <= rsp_rdata_next_s;
            rsp_error_r   <= rsp_error_next_s;
            rsp_timeout_r <= rsp_timeout_next_s;
            cmd_ready_r   <= (count_next_s != CNT_W'(CMD_DEPTH));
            busy_r        <= (count_next_s != '0) || (state_next_s != ST_IDLE);
        end
    end

    // Command storage; contents are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                fifo_write_r[i]  <= 1'b0;
                fifo_addr_r[i]   <= '0;
                fifo_wdata_r[i]  <= '0;
                fifo_strobe_r[i] <= '0;
            end
        end else if (push_s) begin
            fifo_write_r[wr_ptr_r]  <= cmd_write;
            fifo_addr_r[wr_ptr_r]   <= cmd_addr;
            fifo_wdata_r[wr_ptr_r]  <= cmd_wdata;
            fifo_strobe_r[wr_ptr_r] <= cmd_strobe;
        end else begin
            fifo_write_r[wr_ptr_r]  <= fifo_write_r[wr_ptr_r];
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign busy        = busy_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_error   = rsp_error_r;
    assign rsp_timeout = rsp_timeout_r;
    assign bus.wen     = wen_r;
    assign bus.ren     = ren_r;
    assign bus.addr    = addr_r;
    assign bus.wdata   = wdata_r;
    assign bus.strobe  = strobe_r;
endmodule

// File: tb/tb_bus_protocol_initiator.sv
// ---------------------------------------------------------------------------
// tb_bus_protocol_initiator
// Directed bench for bus_protocol_initiator (CMD_DEPTH=4, TIMEOUT_CYCLES=16).
// The slave is modelled by the bench: read data is either a forced value or
// {16'hA5A5, addr[15:0]} so response ordering can be checked by address.
// ---------------------------------------------------------------------------
module tb_bus_protocol_initiator;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_strobe;
    logic            rsp_valid, rsp_ready, rsp_error, rsp_timeout, busy;
    logic [DW-1:0]   rsp_rdata;
    logic            stall_drv, err_drv, rdata_auto;
    logic [DW-1:0]   rdata_drv;
    int              checks = 0;
    int              failures = 0;
    int              n_hi;

    always #5 clk = ~clk;

    bus_protocol_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    assign bus.request_stall = stall_drv;
    assign bus.error         = err_drv;
    assign bus.rdata         = rdata_auto ? {16'hA5A5, bus.addr[15:0]} : rdata_drv;

    bus_protocol_initiator #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strobe(cmd_strobe),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .busy(busy),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input string tag, input int max_cycles);
        int n = 0;
        while (!rsp_valid && n < max_cycles) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    endtask

    task automatic set_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] s);
        cmd_valid  = 1'b1;
        cmd_write  = w;
        cmd_addr   = a;
        cmd_wdata  = d;
        cmd_strobe = s;
    endtask

    initial begin
        logic [AW-1:0] ord_addr [5];
        ord_addr = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
        reset = 1'b1; rsp_ready = 1'b0;
        stall_drv = 1'b0; err_drv = 1'b0; rdata_auto = 1'b0; rdata_drv = 32'h0;
        set_cmd(1'b1, 32'h55, 32'h1234, 4'hF);

        // Reset with cmd_valid high: nothing may be pushed.
        tick(); tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_wen", 64'(bus.wen), 64'd0);
        chk("rst_ren", 64'(bus.ren), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        cmd_valid = 1'b0; reset = 1'b0;
        tick(); tick();
        chk("rst_no_push", 64'(busy), 64'd0);
        chk("rst_no_req", 64'(bus.wen), 64'd0);

        // Write addr=24, zero stall: wen after N+1, response after N+2.
        set_cmd(1'b1, 32'd24, 32'h0F, 4'hF);
        tick();                                   // edge N
        cmd_valid = 1'b0;
        chk("w_no_fallthru", 64'(bus.wen), 64'd0);
        chk("w_busy", 64'(busy), 64'd1);
        tick();                                   // edge N+1
        chk("w_wen", 64'(bus.wen), 64'd1);
        chk("w_ren", 64'(bus.ren), 64'd0);
        chk("w_addr", 64'(bus.addr), 64'd24);
        chk("w_wdata", 64'(bus.wdata), 64'h0F);
        chk("w_strobe", 64'(bus.strobe), 64'hF);
        tick();                                   // edge N+2
        chk("w_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("w_rsp_error", 64'(rsp_error), 64'd0);
        chk("w_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("w_wen_drop", 64'(bus.wen), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("w_rsp_taken", 64'(rsp_valid), 64'd0);
        tick();
        chk("w_idle", 64'(busy), 64'd0);

        // Read addr=8 with 3 stall cycles: ren held 4 cycles, addr stable.
        set_cmd(1'b0, 32'h8, 32'hFFFF_FFFF, 4'hF);
        stall_drv = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("r_ren_stall", 64'(bus.ren), 64'd1);
            chk("r_addr_stable", 64'(bus.addr), 64'h8);
            tick();
        end
        chk("r_ren_4th", 64'(bus.ren), 64'd1);
        chk("r_strobe0", 64'(bus.strobe), 64'd0);
        stall_drv = 1'b0; rdata_drv = 32'hDEADBEEF;
        tick();
        chk("r_ren_drop", 64'(bus.ren), 64'd0);
        chk("r_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("r_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        chk("r_rsp_error", 64'(rsp_error), 64'd0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        rdata_drv = 32'h0; rdata_auto = 1'b1;

        // FIFO fill: park one read in RESP, then offer five reads.
        set_cmd(1'b0, 32'h100, 32'h0, 4'h0);
        tick(); cmd_valid = 1'b0;
        tick(); tick();
        chk("f_park_rsp", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b0, ord_addr[i], 32'h0, 4'h0);
            chk("f_ready_before_push", 64'(cmd_ready), 64'd1);
            tick();
        end
        set_cmd(1'b0, ord_addr[4], 32'h0, 4'h0);
        chk("f_full_after_4", 64'(cmd_ready), 64'd0);
        tick();
        chk("f_full_held", 64'(cmd_ready), 64'd0);
        chk("f_park_rdata", 64'(rsp_rdata), 64'hA5A5_0100);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        chk("f_full_in_idle", 64'(cmd_ready), 64'd0);
        tick();                                   // pop while full: no push
        chk("f_ready_after_pop", 64'(cmd_ready), 64'd1);
        chk("f_first_addr", 64'(bus.addr), 64'h10);
        tick();                                   // fifth command accepted
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_rsp("f_order", 8);
            chk("f_order_rdata", 64'(rsp_rdata), 64'({16'hA5A5, ord_addr[i][15:0]}));
            rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        end
        tick(); tick();
        chk("f_drained", 64'(busy), 64'd0);

        // Timeout: stall stuck high on a read.
        set_cmd(1'b0, 32'h30, 32'h0, 4'h0);
        stall_drv = 1'b1;
        tick(); cmd_valid = 1'b0;
        tick();
        n_hi = 0;
        while (bus.ren && n_hi < 40) begin
            n_hi++;
            tick();
        end
        chk("to_stall_cycles", 64'(n_hi), 64'd16);
        chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("to_rsp_error", 64'(rsp_error), 64'd1);
        chk("to_rsp_timeout", 64'(rsp_timeout), 64'd1);
        chk("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
        stall_drv = 1'b0;
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // Next command after a timeout proceeds normally.
        set_cmd(1'b0, 32'h44, 32'h0, 4'h0);
        tick(); cmd_valid = 1'b0;
        wait_rsp("post_to", 6);
        chk("post_to_rdata", 64'(rsp_rdata), 64'hA5A5_0044);
        chk("post_to_error", 64'(rsp_error), 64'd0);
        chk("post_to_timeout", 64'(rsp_timeout), 64'd0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // Slave error on a write completion.
        set_cmd(1'b1, 32'h48, 32'hCAFE, 4'h3);
        err_drv = 1'b1;
        tick(); cmd_valid = 1'b0;
        wait_rsp("werr", 6);
        chk("werr_error", 64'(rsp_error), 64'd1);
        chk("werr_timeout", 64'(rsp_timeout), 64'd0);
        chk("werr_rdata", 64'(rsp_rdata), 64'd0);
        err_drv = 1'b0;
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // Reset during a stalled write with another command queued.
        stall_drv = 1'b1;
        set_cmd(1'b1, 32'h60, 32'h1, 4'hF);
        tick();
        set_cmd(1'b1, 32'h64, 32'h2, 4'hF);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_wen_before", 64'(bus.wen), 64'd1);
        reset = 1'b1;
        tick();
        chk("mid_wen_dropped", 64'(bus.wen), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_cmd_ready", 64'(cmd_ready), 64'd1);
        reset = 1'b0; stall_drv = 1'b0;
        tick(); tick(); tick();
        chk("mid_fifo_empty", 64'(busy), 64'd0);
        chk("mid_no_reissue", 64'(bus.wen), 64'd0);
        chk("mid_no_rsp", 64'(rsp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
